fpga_clk_div_multi: RTL and testbench

Parametrised multi-channel programmable clock/tick divider for FPGA top-levels. It generates slow clock-enable style outputs from the SoC clock: the RTC reference, fan PWM base, and peripheral sample ticks. Each channel has a runtime divisor that reloads glitch-free at period boundaries, handles odd divisors, and supports per-channel enable and a global phase-aligning clear. All outputs are registered and sit in the soc_clk domain.

---
 rtl/fpga_clk_div_multi.sv | 46 ++++
 tb/tb_fpga_clk_div_multi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fpga_clk_div_multi.sv
// fpga_clk_div_multi: multi-channel programmable clock/tick divider with
// boundary-only divisor reload, odd-divisor duty handling and phase-aligning clear.
module fpga_clk_div_multi #(
   parameter int NumChan    = 2,
   parameter int CntWidth   = 16,
   parameter int DefaultDiv = 50
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumChan-1:0]           en_i,
   input  logic [NumChan*CntWidth-1:0]  div_i,
   input  logic                         clear_i,
   output logic [NumChan-1:0]           clk_o,
   output logic [NumChan-1:0]           tick_o,
   output logic [NumChan*CntWidth-1:0]  div_active_o
);
   for (genvar k = 0; k < NumChan; k++) begin : g_chan
      logic [CntWidth-1:0] cnt_q, div_q, div_req, hi_len;
      logic                run, clk_q, tick_q;
      assign div_req = div_i[k*CntWidth +: CntWidth];
      assign run     = en_i[k] && (div_q >= CntWidth'(2));
      // ceil(div/2) cycles high so odd divisors favour the high phase
      assign hi_len  = div_q - (div_q >> 1);
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= CntWidth'(DefaultDiv);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else if (clear_i || !run) begin
            cnt_q  <= '0;
            div_q  <= div_req;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            clk_q  <= cnt_q < hi_len;
            tick_q <= cnt_q == '0;
            cnt_q  <= (cnt_q == div_q - CntWidth'(1)) ? '0 : cnt_q + CntWidth'(1);
            div_q  <= (cnt_q == div_q - CntWidth'(1)) ? div_req : div_q;
         end
      end
      assign clk_o[k]  = clk_q;
      assign tick_o[k] = tick_q;
      assign div_active_o[k*CntWidth +: CntWidth] = div_q;
   end
endmodule

// File: tb/tb_fpga_clk_div_multi.sv
// tb_fpga_clk_div_multi: scoreboard bench for the two-channel default divider.
module tb_fpga_clk_div_multi;
   logic        clk = 1'b0, rst, clear;
   logic [1:0]  en, clk_o, tick_o;
   logic [31:0] div, div_active;
   typedef struct {logic [1:0] c; logic [1:0] t; logic [31:0] d;} exp_t;
   exp_t sb[$];
   exp_t e;
   int total = 0, bad = 0;

   fpga_clk_div_multi dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .div_i(div), .clear_i(clear),
      .clk_o(clk_o), .tick_o(tick_o), .div_active_o(div_active)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic [1:0] c, logic [1:0] t, logic [31:0] d);
      exp_t x;
      x.c = c; x.t = t; x.d = d;
      sb.push_back(x);
   endtask

   task automatic restart(logic [15:0] d0, logic [15:0] d1, logic [1:0] e_on);
      en = 2'b00;
      div = {d1, d0};
      cyc();
      en = e_on;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; en = 2'b11; div = {16'd50, 16'd50};
      repeat (3) cyc();
      total++;
      if (clk_o !== 2'b00 || tick_o !== 2'b00 || div_active !== {16'd50, 16'd50}) begin
         bad++;
         $display("FAIL reset_hold: clk=%b tick=%b div=%h want 00 00 00320032", clk_o, tick_o, div_active);
      end
      rst = 1'b0;
      for (int i = 0; i < 100; i++)
         push({2{(i % 50) < 25}}, {2{(i % 50) == 0}}, {16'd50, 16'd50});
      for (int i = 0; i < 100; i++) begin
         cyc();
         e = sb.pop_front();
         total++;
         if (clk_o !== e.c || tick_o !== e.t || div_active !== e.d) begin
            bad++;
            $display("FAIL reset_run cyc %0d: clk=%b tick=%b div=%h want %b %b %h", i, clk_o, tick_o, div_active, e.c, e.t, e.d);
         end
      end
   endtask

   task automatic test_odd();
      int dl[3] = '{5, 3, 2};
      foreach (dl[n]) begin
         restart(16'(dl[n]), 16'd7, 2'b01);
         for (int i = 0; i < 3 * dl[n]; i++)
            push({1'b0, (i % dl[n]) < (dl[n] - dl[n] / 2)}, {1'b0, (i % dl[n]) == 0}, {16'd7, 16'(dl[n])});
         for (int i = 0; i < 3 * dl[n]; i++) begin
            cyc();
            e = sb.pop_front();
            total++;
            if (clk_o !== e.c || tick_o !== e.t || div_active !== e.d) begin
               bad++;
               $display("FAIL odd_div%0d cyc %0d: clk=%b tick=%b div=%h want %b %b %h", dl[n], i, clk_o, tick_o, div_active, e.c, e.t, e.d);
            end
         end
      end
      restart(16'hFFFF, 16'd7, 2'b01);
      for (int i = 0; i < 6; i++) push(2'b01, {1'b0, i == 0}, {16'd7, 16'hFFFF});
      for (int i = 0; i < 6; i++) begin
         cyc();
         e = sb.pop_front();
         total++;
         if (clk_o !== e.c || tick_o !== e.t || div_active !== e.d) begin
            bad++;
            $display("FAIL max_div cyc %0d: clk=%b tick=%b div=%h want %b %b %h", i, clk_o, tick_o, div_active, e.c, e.t, e.d);
         end
      end
   endtask

   task automatic test_reload();
      restart(16'd10, 16'd7, 2'b01);
      for (int i = 0; i < 10; i++)
         push({1'b0, i < 5}, {1'b0, i == 0}, {16'd7, (i < 9) ? 16'd10 : 16'd4});
      for (int i = 10; i < 22; i++)
         push({1'b0, ((i - 10) % 4) < 2}, {1'b0, ((i - 10) % 4) == 0}, {16'd7, 16'd4});
      for (int i = 0; i < 22; i++) begin
         if (i == 3) div = {16'd7, 16'd4};
         cyc();
         e = sb.pop_front();
         total++;
         if (clk_o !== e.c || tick_o !== e.t || div_active !== e.d) begin
            bad++;
            $display("FAIL reload cyc %0d: clk=%b tick=%b div=%h want %b %b %h", i, clk_o, tick_o, div_active, e.c, e.t, e.d);
         end
      end
   endtask

   task automatic test_disable();
      restart(16'd8, 16'd7, 2'b01);
      for (int i = 0; i < 28; i++) begin
         logic [15:0] d0;
         d0 = (i < 3) ? 16'd8 : (i < 8) ? 16'd1 : 16'd6;
         if (i < 2)      push(2'b01, {1'b0, i == 0}, {16'd7, d0});
         else if (i < 9) push(2'b00, 2'b00, {16'd7, d0});
         else            push({1'b0, ((i - 9) % 6) < 3}, {1'b0, ((i - 9) % 6) == 0}, {16'd7, d0});
      end
      for (int i = 0; i < 28; i++) begin
         if (i == 2) en = 2'b00;
         if (i == 3) div = {16'd7, 16'd1};
         if (i == 4) en = 2'b01;
         if (i == 8) div = {16'd7, 16'd6};
         cyc();
         e = sb.pop_front();
         total++;
         if (clk_o !== e.c || tick_o !== e.t || div_active !== e.d) begin
            bad++;
            $display("FAIL disable cyc %0d: clk=%b tick=%b div=%h want %b %b %h", i, clk_o, tick_o, div_active, e.c, e.t, e.d);
         end
      end
   endtask

   task automatic test_clear();
      restart(16'd6, 16'd12, 2'b01);
      repeat (5) cyc();
      en = 2'b11;
      repeat (3) cyc();
      clear = 1'b1;
      push(2'b00, 2'b00, {16'd12, 16'd6});
      for (int i = 1; i < 26; i++)
         push({((i - 1) % 12) < 6, ((i - 1) % 6) < 3}, {((i - 1) % 12) == 0, ((i - 1) % 6) == 0}, {16'd12, 16'd6});
      for (int i = 0; i < 26; i++) begin
         cyc();
         clear = 1'b0;
         e = sb.pop_front();
         total++;
         if (clk_o !== e.c || tick_o !== e.t || div_active !== e.d) begin
            bad++;
            $display("FAIL clear cyc %0d: clk=%b tick=%b div=%h want %b %b %h", i, clk_o, tick_o, div_active, e.c, e.t, e.d);
         end
      end
   endtask

   task automatic test_async_reset();
      restart(16'd6, 16'd9, 2'b11);
      cyc();
      total++;
      if (clk_o !== 2'b11 || tick_o !== 2'b11) begin
         bad++;
         $display("FAIL pre_rst: clk=%b tick=%b want 11 11", clk_o, tick_o);
      end
      #3 rst = 1'b1;
      #1;
      total++;
      if (clk_o !== 2'b00 || tick_o !== 2'b00 || div_active !== {16'd50, 16'd50}) begin
         bad++;
         $display("FAIL async_rst: clk=%b tick=%b div=%h want 00 00 00320032", clk_o, tick_o, div_active);
      end
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (i < 50) push({2{i < 25}}, {2{i == 0}}, (i < 49) ? {16'd50, 16'd50} : {16'd9, 16'd6});
         else push({((i - 50) % 9) < 5, ((i - 50) % 6) < 3}, {((i - 50) % 9) == 0, ((i - 50) % 6) == 0}, {16'd9, 16'd6});
      end
      for (int i = 0; i < 70; i++) begin
         cyc();
         e = sb.pop_front();
         total++;
         if (clk_o !== e.c || tick_o !== e.t || div_active !== e.d) begin
            bad++;
            $display("FAIL post_rst cyc %0d: clk=%b tick=%b div=%h want %b %b %h", i, clk_o, tick_o, div_active, e.c, e.t, e.d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_odd();
      test_reload();
      test_disable();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
